mips_ctrl_alu: RTL and testbench

MIPS_CTRL_ALU -- requirements
Module: mips_ctrl_alu

---
 rtl/mips_pkg.sv | 78 +++++++
 rtl/mips_alu.sv | 33 +++
 rtl/mips_ctrl_alu.sv | 178 +++++++++++++++++
 tb/tb_mips_ctrl_alu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control/ALU slice.
// Holds the opcode and funct values, the ALU operation and next-PC source
// encodings, the decoded-control bundle, and the immediate-extension helper.
package mips_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_BSZ   = 6'h14;
  localparam logic [5:0] OP_BSNZ  = 6'h15;
  localparam logic [5:0] OP_JM    = 6'h16;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,  // sequential or conditional branch
    PC_JUMP = 2'b01,  // addr26 jump target
    PC_REG  = 2'b10,  // rs_data
    PC_MEM  = 2'b11   // memory data
  } pc_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    write_reg31;
    logic    link;
    logic    alu_src;
    logic    ext_op;
    logic    mem_write;
    logic    mem_to_reg;
    logic    is_jump;
    logic    zero_branch;
    logic    need_zero;
    logic    status_branch;
    logic    need_st_z;
    alu_op_e alu_op;
    pc_sel_e pc_select;
  } ctrl_t;

  // Sign- or zero-extend a 16-bit immediate to 32 bits.
  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sign_ext);
    return sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU.
// Ports: a_i/b_i operands, shamt_i shift amount (applies to b_i),
// alu_op_i operation select, result_o result, zero_o (result_o == 0).
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  input  alu_op_e     alu_op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  // Operation select; add/sub wrap modulo 2^32
  always_comb begin
    result_o = 32'h0000_0000;
    case (alu_op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = b_i << shamt_i;
      ALU_SRL: result_o = b_i >> shamt_i;
      ALU_SLT: result_o = ($signed(a_i) < $signed(b_i)) ? 32'h0000_0001 : 32'h0000_0000;
      default: result_o = 32'h0000_0000;
    endcase
  end

  assign zero_o = (result_o == 32'h0000_0000);

endmodule

// File: rtl/mips_ctrl_alu.sv
// MIPS instruction decoder plus ALU with a registered zero-status flag.
// Inputs: clk, rst_n (synchronous active-low), instruction, rs_data, rt_data.
// Outputs: decode controls, branch/jump controls, alu_op, pc_select,
// alu_out/alu_zout (combinational) and st_z (registered alu_zout).
module mips_ctrl_alu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        write_reg31,
  output logic        link,
  output logic        alu_src,
  output logic        ext_op,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        is_jump,
  output logic        zero_branch,
  output logic        need_zero,
  output logic        status_branch,
  output logic        need_st_z,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_select,
  output logic [31:0] alu_out,
  output logic        alu_zout,
  output logic        st_z
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  ctrl_t       ctrl;
  logic [31:0] alu_b;
  logic        st_z_d;
  logic        st_z_q;
  logic        unused_fields;

  assign op    = instruction[31:26];
  assign funct = instruction[5:0];
  assign shamt = instruction[10:6];
  assign imm16 = instruction[15:0];
  // Register-number fields are consumed by the register file, not here.
  assign unused_fields = ^instruction[25:16];

  // Instruction decode; unlisted op/funct leaves every control at 0 (NOP)
  always_comb begin
    ctrl = '0;
    ctrl.alu_op    = ALU_ADD;
    ctrl.pc_select = PC_SEQ;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          F_ADD, F_ADDU: ctrl.alu_op = ALU_ADD;
          F_SUB, F_SUBU: ctrl.alu_op = ALU_SUB;
          F_AND:         ctrl.alu_op = ALU_AND;
          F_OR:          ctrl.alu_op = ALU_OR;
          F_XOR:         ctrl.alu_op = ALU_XOR;
          F_SLT:         ctrl.alu_op = ALU_SLT;
          F_SLL:         ctrl.alu_op = ALU_SLL;
          F_SRL:         ctrl.alu_op = ALU_SRL;
          F_JR: begin
            ctrl           = '0;
            ctrl.alu_op    = ALU_ADD;
            ctrl.is_jump   = 1'b1;
            ctrl.pc_select = PC_REG;
          end
          default: begin
            ctrl           = '0;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_select = PC_SEQ;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        // Arithmetic immediates sign-extend, logical ones zero-extend
        ctrl.ext_op    = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI);
        case (op)
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_XORI: ctrl.alu_op = ALU_XOR;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.ext_op     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_op      = ALU_SUB;
        ctrl.zero_branch = 1'b1;
        ctrl.need_zero   = (op == OP_BEQ);
      end
      OP_J: begin
        ctrl.is_jump   = 1'b1;
        ctrl.pc_select = PC_JUMP;
      end
      OP_JAL: begin
        // reg_write stays 0: the link write is gated by 'link' downstream
        ctrl.is_jump     = 1'b1;
        ctrl.pc_select   = PC_JUMP;
        ctrl.link        = 1'b1;
        ctrl.write_reg31 = 1'b1;
      end
      OP_BSZ, OP_BSNZ: begin
        ctrl.status_branch = 1'b1;
        ctrl.need_st_z     = (op == OP_BSZ);
      end
      OP_JM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = 1'b1;
        ctrl.is_jump   = 1'b1;
        ctrl.pc_select = PC_MEM;
      end
      default: begin
        ctrl           = '0;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_select = PC_SEQ;
      end
    endcase
  end

  assign alu_b = ctrl.alu_src ? ext_imm(imm16, ctrl.ext_op) : rt_data;

  mips_alu u_alu (
    .a_i      (rs_data),
    .b_i      (alu_b),
    .shamt_i  (shamt),
    .alu_op_i (ctrl.alu_op),
    .result_o (alu_out),
    .zero_o   (alu_zout)
  );

  assign st_z_d = alu_zout;

  // Zero-status register, captured every cycle; reset wins over the update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_z_q <= 1'b0;
    end else begin
      st_z_q <= st_z_d;
    end
  end

  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign write_reg31   = ctrl.write_reg31;
  assign link          = ctrl.link;
  assign alu_src       = ctrl.alu_src;
  assign ext_op        = ctrl.ext_op;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign is_jump       = ctrl.is_jump;
  assign zero_branch   = ctrl.zero_branch;
  assign need_zero     = ctrl.need_zero;
  assign status_branch = ctrl.status_branch;
  assign need_st_z     = ctrl.need_st_z;
  assign alu_op        = ctrl.alu_op;
  assign pc_select     = ctrl.pc_select;
  assign st_z          = st_z_q;

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// Directed self-checking bench for mips_ctrl_alu.
// Control outputs are packed into one vector, ordered:
// {rw, rd, w31, lk, as, ex, mw, m2r, ij, zb, nz, sb, nsz, alu_op[2:0], pc_select[1:0]}
module tb_mips_ctrl_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        reg_write, reg_dst, write_reg31, link, alu_src, ext_op, mem_write, mem_to_reg;
  logic        is_jump, zero_branch, need_zero, status_branch, need_st_z;
  logic [2:0]  alu_op;
  logic [1:0]  pc_select;
  logic [31:0] alu_out;
  logic        alu_zout;
  logic        st_z;
  logic [17:0] ctrl_obs;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mips_ctrl_alu dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .rs_data(rs_data), .rt_data(rt_data),
    .reg_write(reg_write), .reg_dst(reg_dst), .write_reg31(write_reg31), .link(link),
    .alu_src(alu_src), .ext_op(ext_op), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .is_jump(is_jump), .zero_branch(zero_branch), .need_zero(need_zero),
    .status_branch(status_branch), .need_st_z(need_st_z),
    .alu_op(alu_op), .pc_select(pc_select),
    .alu_out(alu_out), .alu_zout(alu_zout), .st_z(st_z)
  );

  assign ctrl_obs = {reg_write, reg_dst, write_reg31, link, alu_src, ext_op, mem_write,
                     mem_to_reg, is_jump, zero_branch, need_zero, status_branch, need_st_z,
                     alu_op, pc_select};

  function automatic logic [31:0] rtype(input logic [4:0] shamt, input logic [5:0] funct);
    return {6'h00, 5'd1, 5'd2, 5'd3, shamt, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  // Apply operands between clock edges, then let combinational logic settle
  task automatic apply(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    instruction = ins;
    rs_data     = rs;
    rt_data     = rt;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    apply(rtype(5'd0, 6'h20), 32'd1, 32'd1);
    @(posedge clk); #1;
    total++;
    if (st_z !== 1'b0) $display("FAIL reset_st_z got %b exp 0", st_z);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    apply(rtype(5'd0, 6'h20), 32'd5, 32'd7);
    total++;
    if (alu_out !== 32'd12) $display("FAIL add_out got %h exp %h", alu_out, 32'd12);
    else passed++;
    total++;
    if (ctrl_obs !== {13'b1100000000000, 3'b000, 2'b00}) $display("FAIL add_ctrl got %b exp %b", ctrl_obs, {13'b1100000000000, 3'b000, 2'b00});
    else passed++;
    total++;
    if (alu_zout !== 1'b0) $display("FAIL add_zout got %b exp 0", alu_zout);
    else passed++;
    // sub wraps: 0 - 1
    apply(rtype(5'd0, 6'h22), 32'd0, 32'd1);
    total++;
    if (alu_out !== 32'hFFFF_FFFF || alu_op !== 3'b001) $display("FAIL sub_wrap got %h/%b exp ffffffff/001", alu_out, alu_op);
    else passed++;
    // xor
    apply(rtype(5'd0, 6'h26), 32'hF0F0_0000, 32'hFF00_00FF);
    total++;
    if (alu_out !== 32'h0FF0_00FF || alu_op !== 3'b100) $display("FAIL xor got %h/%b exp 0ff000ff/100", alu_out, alu_op);
    else passed++;
  endtask

  task automatic test_immediate;
    apply(itype(6'h08, 16'hFFFF), 32'd1, 32'd99);
    total++;
    if (alu_out !== 32'd0 || alu_zout !== 1'b1) $display("FAIL addi_out got %h/%b exp 0/1", alu_out, alu_zout);
    else passed++;
    total++;
    if (ctrl_obs !== {13'b1000110000000, 3'b000, 2'b00}) $display("FAIL addi_ctrl got %b exp %b", ctrl_obs, {13'b1000110000000, 3'b000, 2'b00});
    else passed++;
    @(posedge clk); #1;
    total++;
    if (st_z !== 1'b1) $display("FAIL addi_st_z got %b exp 1", st_z);
    else passed++;
    apply(itype(6'h0C, 16'hFFFF), 32'd1, 32'd99);
    total++;
    if (alu_out !== 32'd1) $display("FAIL andi_out got %h exp 1", alu_out);
    else passed++;
    total++;
    if (ctrl_obs !== {13'b1000100000000, 3'b010, 2'b00}) $display("FAIL andi_ctrl got %b exp %b", ctrl_obs, {13'b1000100000000, 3'b010, 2'b00});
    else passed++;
    apply(itype(6'h0D, 16'h0F0F), 32'h0000_00F0, 32'd0);
    total++;
    if (alu_out !== 32'h0000_0FFF || alu_op !== 3'b011) $display("FAIL ori got %h/%b exp 00000fff/011", alu_out, alu_op);
    else passed++;
    apply(itype(6'h23, 16'h8000), 32'h0000_1000, 32'd0);
    total++;
    if (alu_out !== 32'hFFFF_9000 || ctrl_obs !== {13'b1000110100000, 3'b000, 2'b00}) $display("FAIL lw got %h/%b exp ffff9000/%b", alu_out, ctrl_obs, {13'b1000110100000, 3'b000, 2'b00});
    else passed++;
    apply(itype(6'h2B, 16'h0004), 32'h0000_0010, 32'd0);
    total++;
    if (alu_out !== 32'h0000_0014 || ctrl_obs !== {13'b0000111000000, 3'b000, 2'b00}) $display("FAIL sw got %h/%b exp 00000014/%b", alu_out, ctrl_obs, {13'b0000111000000, 3'b000, 2'b00});
    else passed++;
  endtask

  task automatic test_shift_slt;
    apply(rtype(5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1);
    total++;
    if (alu_out !== 32'd1 || alu_op !== 3'b111) $display("FAIL slt got %h/%b exp 1/111", alu_out, alu_op);
    else passed++;
    apply(rtype(5'd31, 6'h00), 32'd0, 32'd1);
    total++;
    if (alu_out !== 32'h8000_0000 || alu_op !== 3'b101) $display("FAIL sll got %h/%b exp 80000000/101", alu_out, alu_op);
    else passed++;
    apply(rtype(5'd31, 6'h02), 32'd0, 32'h8000_0000);
    total++;
    if (alu_out !== 32'd1 || alu_op !== 3'b110) $display("FAIL srl got %h/%b exp 1/110", alu_out, alu_op);
    else passed++;
  endtask

  task automatic test_branch;
    apply(itype(6'h04, 16'h0010), 32'd9, 32'd9);
    total++;
    if (ctrl_obs !== {13'b0000000001100, 3'b001, 2'b00} || alu_zout !== 1'b1) $display("FAIL beq got %b/%b exp %b/1", ctrl_obs, alu_zout, {13'b0000000001100, 3'b001, 2'b00});
    else passed++;
    apply(itype(6'h05, 16'h0010), 32'd9, 32'd9);
    total++;
    if (ctrl_obs !== {13'b0000000001000, 3'b001, 2'b00}) $display("FAIL bne got %b exp %b", ctrl_obs, {13'b0000000001000, 3'b001, 2'b00});
    else passed++;
    apply(itype(6'h14, 16'h0010), 32'd1, 32'd2);
    total++;
    if (ctrl_obs !== {13'b0000000000011, 3'b000, 2'b00}) $display("FAIL bsz got %b exp %b", ctrl_obs, {13'b0000000000011, 3'b000, 2'b00});
    else passed++;
    apply(itype(6'h15, 16'h0010), 32'd1, 32'd2);
    total++;
    if (ctrl_obs !== {13'b0000000000010, 3'b000, 2'b00}) $display("FAIL bsnz got %b exp %b", ctrl_obs, {13'b0000000000010, 3'b000, 2'b00});
    else passed++;
  endtask

  task automatic test_jump;
    apply({6'h03, 26'h0000123}, 32'd0, 32'd0);
    total++;
    if (ctrl_obs !== {13'b0011000010000, 3'b000, 2'b01}) $display("FAIL jal got %b exp %b", ctrl_obs, {13'b0011000010000, 3'b000, 2'b01});
    else passed++;
    apply({6'h02, 26'h0000123}, 32'd0, 32'd0);
    total++;
    if (ctrl_obs !== {13'b0000000010000, 3'b000, 2'b01}) $display("FAIL j got %b exp %b", ctrl_obs, {13'b0000000010000, 3'b000, 2'b01});
    else passed++;
    apply(rtype(5'd0, 6'h08), 32'h0000_4000, 32'd0);
    total++;
    if (ctrl_obs !== {13'b0000000010000, 3'b000, 2'b10}) $display("FAIL jr got %b exp %b", ctrl_obs, {13'b0000000010000, 3'b000, 2'b10});
    else passed++;
    apply(itype(6'h16, 16'hFFFC), 32'h0000_0100, 32'd0);
    total++;
    if (alu_out !== 32'h0000_00FC || ctrl_obs !== {13'b0000110010000, 3'b000, 2'b11}) $display("FAIL jm got %h/%b exp 000000fc/%b", alu_out, ctrl_obs, {13'b0000110010000, 3'b000, 2'b11});
    else passed++;
    apply(itype(6'h3F, 16'hFFFF), 32'd3, 32'd4);
    total++;
    if (ctrl_obs !== 18'd0 || alu_out !== 32'd7) $display("FAIL nop_op got %b/%h exp 0/7", ctrl_obs, alu_out);
    else passed++;
    apply(rtype(5'd0, 6'h3F), 32'd3, 32'd4);
    total++;
    if (ctrl_obs !== 18'd0 || alu_out !== 32'd7) $display("FAIL nop_funct got %b/%h exp 0/7", ctrl_obs, alu_out);
    else passed++;
  endtask

  task automatic test_reset_mid;
    apply(itype(6'h08, 16'hFFFF), 32'd1, 32'd0);
    @(posedge clk); #1;
    total++;
    if (st_z !== 1'b1) $display("FAIL mid_set got %b exp 1", st_z);
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (st_z !== 1'b0) $display("FAIL mid_reset got %b exp 0", st_z);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    instruction = rtype(5'd0, 6'h20);
    rs_data = 32'd1;
    rt_data = 32'd2;
    @(posedge clk); #1;
    total++;
    if (st_z !== 1'b0 || alu_out !== 32'd3) $display("FAIL mid_release got %b/%h exp 0/3", st_z, alu_out);
    else passed++;
    apply(rtype(5'd0, 6'h22), 32'd6, 32'd6);
    @(posedge clk); #1;
    total++;
    if (st_z !== 1'b1) $display("FAIL mid_resume got %b exp 1", st_z);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    instruction = 32'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    test_reset;
    test_add;
    test_immediate;
    test_shift_slt;
    test_branch;
    test_jump;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
